ndrot_pulse_sequencer: RTL and testbench

Synchronous command sequencer that drives one toggle-encoded NDROT cell and reads its result back. Each SFQ pulse is represented as a level toggle (either edge = one pulse) on `a_out` (set), `b_out` (reset) and `clk_out` (readout clock). Each toggle on the cell's `q` is captured on `q_in`. The block queues SET/RESET/READ/WAIT commands, enforces minimum inter-pulse spacing so that the cell's critical-timing windows are never violated, and returns one response bit per READ. It sits directly upstream of the NDROT (it feeds a, b, clk) and also consumes its q.

---
 rtl/ndrot_pulse_sequencer.sv | 168 ++++++++++++++++
 tb/tb_ndrot_pulse_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ndrot_pulse_sequencer.sv
// Command sequencer for a toggle-encoded NDROT cell: queues SET/RESET/READ/WAIT,
// spaces the emitted pulses and checks each readout against a shadow copy of the cell.
module ndrot_pulse_sequencer #(
  parameter int DEPTH    = 4,
  parameter int MIN_GAP  = 3,
  parameter int READ_WIN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  output logic       a_out,
  output logic       b_out,
  output logic       clk_out,
  input  logic       q_in,
  output logic       rsp_valid,
  output logic       rsp_data,
  output logic       spur_err,
  output logic       mism_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MIN_GAP + READ_WIN + 1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL   = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] TMR_ONE    = CW'(1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(MIN_GAP - 1);
  localparam logic [CW-1:0] WIN_LAST   = CW'(READ_WIN - 1);
  localparam logic [2:0]    BLANK_DONE = 3'd5;
  localparam logic [1:0]    CMD_WAIT   = 2'b00;
  localparam logic [1:0]    CMD_SET    = 2'b01;
  localparam logic [1:0]    CMD_RESET  = 2'b10;
  localparam logic [1:0]    CMD_READ   = 2'b11;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GAP = 2'd1, ST_RWIN = 2'd2} state_t;

  state_t        state_r;
  logic [CW-1:0] tmr_r;
  logic          sh_r, seen_r, win_flag_r, rsp_pend_r;
  logic          sync1_r, sync2_r, sync3_r;
  logic [2:0]    blank_r;
  logic [1:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r;
  logic          full_s, empty_s, push_s, pop_s, event_s, hit_s, result_s;
  logic [1:0]    head_s;

  assign full_s    = (count_r == CNT_FULL);
  assign empty_s   = (count_r == '0);
  assign cmd_ready = rst_n & ~full_s;
  assign push_s    = cmd_valid & cmd_ready;
  assign pop_s     = (state_r == ST_IDLE) & ~empty_s;
  assign head_s    = mem_r[rd_ptr_r];
  // Blanking runs two extra cycles so q_in changes from the first three cycles drain out of the synchronizer.
  assign event_s   = (sync2_r ^ sync3_r) & (blank_r == BLANK_DONE);
  // An event is judged by the state on the edge it landed, one cycle before it is seen here.
  assign hit_s     = event_s & win_flag_r;
  assign result_s  = seen_r | hit_s;

  // Command FIFO storage and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= cmd;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // q_in synchronizer, edge-detect flop and post-reset blanking counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
      blank_r <= 3'd0;
    end else begin
      sync1_r <= q_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      if (blank_r != BLANK_DONE) blank_r <= blank_r + 3'd1;
    end
  end

  // Sequencer FSM with registered pulse, response and sticky error outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      tmr_r      <= '0;
      sh_r       <= 1'b0;
      seen_r     <= 1'b0;
      win_flag_r <= 1'b0;
      rsp_pend_r <= 1'b0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      clk_out    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 1'b0;
      spur_err   <= 1'b0;
      mism_err   <= 1'b0;
    end else begin
      win_flag_r <= (state_r == ST_RWIN);
      rsp_pend_r <= 1'b0;
      rsp_valid  <= rsp_pend_r;
      if (rsp_pend_r) begin
        rsp_data <= result_s;
        if (result_s != sh_r) mism_err <= 1'b1;
      end
      if (event_s && (!win_flag_r || seen_r)) spur_err <= 1'b1;
      if (hit_s) seen_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (!empty_s) begin
            tmr_r <= '0;
            case (head_s)
              CMD_SET: begin
                a_out   <= ~a_out;
                sh_r    <= 1'b1;
                state_r <= ST_GAP;
              end
              CMD_RESET: begin
                b_out   <= ~b_out;
                sh_r    <= 1'b0;
                state_r <= ST_GAP;
              end
              CMD_READ: begin
                clk_out <= ~clk_out;
                seen_r  <= 1'b0;
                state_r <= ST_RWIN;
              end
              CMD_WAIT: state_r <= ST_GAP;
              default:  state_r <= ST_GAP;
            endcase
          end
        end
        ST_GAP: begin
          if (tmr_r == GAP_LAST) begin
            tmr_r   <= '0;
            state_r <= ST_IDLE;
          end else begin
            tmr_r <= tmr_r + TMR_ONE;
          end
        end
        ST_RWIN: begin
          if (tmr_r == WIN_LAST) begin
            tmr_r      <= '0;
            rsp_pend_r <= 1'b1;
            state_r    <= ST_GAP;
          end else begin
            tmr_r <= tmr_r + TMR_ONE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ndrot_pulse_sequencer.sv
// Directed bench for ndrot_pulse_sequencer: pulse timing, read windows, FIFO fill,
// spurious/mismatch flags and mid-window reset, with hand-computed expectations.
module tb_ndrot_pulse_sequencer;
  localparam logic [1:0] C_WAIT  = 2'b00;
  localparam logic [1:0] C_SET   = 2'b01;
  localparam logic [1:0] C_RESET = 2'b10;
  localparam logic [1:0] C_READ  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n, cmd_valid, q_in;
  logic [1:0] cmd;
  logic       cmd_ready, a_out, b_out, clk_out, rsp_valid, rsp_data, spur_err, mism_err;
  logic [6:0] outs;
  logic [1:0] seq [5];
  logic       exp_a, exp_b, exp_c;
  int         checks = 0;
  int         failures = 0;

  ndrot_pulse_sequencer #(.DEPTH(4), .MIN_GAP(3), .READ_WIN(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .a_out(a_out), .b_out(b_out), .clk_out(clk_out), .q_in(q_in),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .spur_err(spur_err), .mism_err(mism_err)
  );

  always #5 clk = ~clk;
  assign outs = {a_out, b_out, clk_out, rsp_valid, rsp_data, spur_err, mism_err};

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push2(input logic [1:0] c0, input logic [1:0] c1);
    cmd_valid = 1'b1;
    cmd = c0;
    tick(1);
    cmd = c1;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = C_WAIT; q_in = 1'b0;
    seq[0] = C_SET; seq[1] = C_RESET; seq[2] = C_SET; seq[3] = C_RESET; seq[4] = C_SET;
    tick(3);
    chk("reset_outs", 8'(outs), 8'd0);
    chk("reset_ready", 8'(cmd_ready), 8'd0);
    rst_n = 1'b1;
    #1;
    chk("release_ready", 8'(cmd_ready), 8'd1);

    // SET, READ with the cell answering two cycles after the readout pulse
    push2(C_SET, C_READ);
    chk("set_a_tog", 8'(a_out), 8'd1);
    tick(3);
    chk("read_not_yet", 8'(clk_out), 8'd0);
    tick(1);
    chk("read_clk_tog", 8'(clk_out), 8'd1);
    tick(2);
    q_in = 1'b1;
    tick(2);
    chk("rsp1_early", 8'(rsp_valid), 8'd0);
    tick(1);
    chk("rsp1", 8'({rsp_valid, rsp_data, spur_err, mism_err}), 8'(4'b1100));
    tick(1);
    chk("rsp1_strobe", 8'(rsp_valid), 8'd0);

    // RESET, READ without answer: consistent zero
    tick(2);
    push2(C_RESET, C_READ);
    chk("reset_b_tog", 8'(b_out), 8'd1);
    tick(9);
    chk("rsp2", 8'({rsp_valid, rsp_data, spur_err, mism_err}), 8'(4'b1000));

    // SET, READ without answer: mismatch
    tick(2);
    push2(C_SET, C_READ);
    chk("set2_a_tog", 8'(a_out), 8'd0);
    tick(9);
    chk("rsp3", 8'({rsp_valid, rsp_data, spur_err, mism_err}), 8'(4'b1001));
    tick(3);
    chk("mism_sticky", 8'({spur_err, mism_err}), 8'(2'b01));

    // Five back-to-back commands plus one attempted while full
    exp_a = 1'b0; exp_b = 1'b1; exp_c = 1'b1;
    for (int i = 0; i < 22; i++) begin
      cmd_valid = (i <= 5);
      cmd = (i < 5) ? seq[i] : C_RESET;
      if (i <= 6) chk("burst_ready", 8'(cmd_ready), 8'(i != 5));
      tick(1);
      if (i >= 1 && ((i - 1) % 4) == 0 && ((i - 1) / 4) < 5) begin
        if (seq[(i - 1) / 4] == C_SET) exp_a = ~exp_a;
        else exp_b = ~exp_b;
      end
      chk("burst_pulses", 8'({a_out, b_out, clk_out}), 8'({exp_a, exp_b, exp_c}));
    end
    cmd_valid = 1'b0;

    // Two q_in toggles inside one read window
    cmd_valid = 1'b1; cmd = C_READ;
    tick(1);
    cmd_valid = 1'b0;
    tick(1);
    chk("dbl_clk_tog", 8'(clk_out), 8'd0);
    q_in = 1'b0;
    tick(2);
    q_in = 1'b1;
    tick(2);
    chk("dbl_spur_early", 8'(spur_err), 8'd0);
    tick(1);
    chk("dbl_rsp", 8'({rsp_valid, rsp_data, spur_err}), 8'(3'b111));

    // Reset while a read window is open, with queued commands behind it
    tick(2);
    cmd_valid = 1'b1; cmd = C_READ;
    tick(1);
    cmd = C_SET;
    tick(2);
    cmd_valid = 1'b0;
    chk("rwin_clk_tog", 8'(clk_out), 8'd1);
    q_in = 1'b0;
    tick(1);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_outs", 8'(outs), 8'd0);
    chk("midrst_ready", 8'(cmd_ready), 8'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", 8'(cmd_ready), 8'd1);
    tick(1);
    q_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("post_rst_quiet", 8'(outs), 8'd0);
    end

    // Answer landing one edge past the window is spurious
    cmd_valid = 1'b1; cmd = C_READ;
    tick(1);
    cmd_valid = 1'b0;
    tick(1);
    chk("late_clk_tog", 8'(clk_out), 8'd1);
    tick(3);
    q_in = 1'b0;
    tick(2);
    chk("late_rsp", 8'({rsp_valid, rsp_data, spur_err, mism_err}), 8'(4'b1000));
    tick(1);
    chk("late_spur", 8'({rsp_valid, spur_err}), 8'(2'b01));

    // WAIT emits nothing and delays the following SET
    tick(2);
    push2(C_WAIT, C_SET);
    chk("wait_silent", 8'({a_out, b_out, clk_out}), 8'(3'b001));
    tick(3);
    chk("wait_set_early", 8'(a_out), 8'd0);
    tick(1);
    chk("wait_set_tog", 8'(a_out), 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
